// File: rtl/sdhci_dat_busy_detector.sv
// rtl/sdhci_dat_busy_detector.sv - DAT0 CRC status token and busy detector with timeout
module sdhci_dat_busy_detector #(
  parameter int TimeoutWidth = 24,
  parameter int StartWindow  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sd_clk_en_i,
  input  logic                    dat0_i,
  input  logic                    start_i,
  input  logic                    busy_only_i,
  input  logic                    abort_i,
  input  logic [TimeoutWidth-1:0] timeout_limit_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    crc_error_o,
  output logic                    end_bit_error_o,
  output logic                    timeout_error_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    STATUS,
    END_BIT,
    BUSY_MIN,
    BUSY,
    FINISH
  } state_e;

  localparam logic [TimeoutWidth-1:0] StartWindowCnt = TimeoutWidth'(StartWindow);

  state_e                  state_q, state_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]              bit_cnt_q, bit_cnt_d;
  logic [2:0]              token_q, token_d;
  logic                    crc_flag_q, crc_flag_d;
  logic                    end_flag_q, end_flag_d;
  logic                    tmo_hit;
  logic                    limit_hit;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    crc_err_q, crc_err_d;
  logic                    end_err_q, end_err_d;
  logic                    tmo_err_q, tmo_err_d;

  // Saturating sample counter shared by the start window and the busy timeout
  always_comb begin
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    limit_hit = (timeout_limit_i != '0) && (cnt_inc == timeout_limit_i);
  end

  // Next-state and next-output logic; abort overrides everything else
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    token_d    = token_q;
    crc_flag_d = crc_flag_q;
    end_flag_d = end_flag_q;
    tmo_hit    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = WAIT_START;
          cnt_d      = '0;
          crc_flag_d = 1'b0;
          end_flag_d = 1'b0;
        end else if (busy_only_i) begin
          state_d    = BUSY_MIN;
          cnt_d      = '0;
          bit_cnt_d  = 2'd0;
          crc_flag_d = 1'b0;
          end_flag_d = 1'b0;
        end
      end
      WAIT_START: begin
        if (sd_clk_en_i) begin
          if (!dat0_i) begin
            state_d   = STATUS;
            bit_cnt_d = 2'd0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == StartWindowCnt) begin
              state_d = FINISH;
              tmo_hit = 1'b1;
            end
          end
        end
      end
      STATUS: begin
        if (sd_clk_en_i) begin
          token_d   = {token_q[1:0], dat0_i};
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd2) begin
            state_d = END_BIT;
          end
        end
      end
      END_BIT: begin
        if (sd_clk_en_i) begin
          end_flag_d = !dat0_i;
          crc_flag_d = (token_q != 3'b010);
          state_d    = BUSY_MIN;
          cnt_d      = '0;
          bit_cnt_d  = 2'd0;
        end
      end
      BUSY_MIN: begin
        if (sd_clk_en_i) begin
          cnt_d     = cnt_inc;
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (limit_hit) begin
            state_d = FINISH;
            tmo_hit = 1'b1;
          end else if (bit_cnt_q == 2'd1) begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (sd_clk_en_i) begin
          cnt_d = cnt_inc;
          if (dat0_i) begin
            state_d = FINISH;
          end else if (limit_hit) begin
            state_d = FINISH;
            tmo_hit = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d    = IDLE;
        crc_flag_d = 1'b0;
        end_flag_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d    = IDLE;
      crc_flag_d = 1'b0;
      end_flag_d = 1'b0;
      tmo_hit    = 1'b0;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FINISH);
    crc_err_d = done_d & crc_flag_d;
    end_err_d = done_d & end_flag_d;
    tmo_err_d = done_d & tmo_hit;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 2'd0;
      token_q    <= 3'd0;
      crc_flag_q <= 1'b0;
      end_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      token_q    <= token_d;
      crc_flag_q <= crc_flag_d;
      end_flag_q <= end_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign crc_error_o     = crc_err_q;
  assign end_bit_error_o = end_err_q;
  assign timeout_error_o = tmo_err_q;

endmodule
